// File: rtl/ir_transmitter.sv
// SIRC-style IR frame transmitter: start burst, 12 LSB-first pulse-width data
// marks separated by gaps, all modulated onto a square-wave carrier.
module ir_transmitter #(
    parameter int UNIT         = 15000,
    parameter int START_UNITS  = 4,
    parameter int ONE_UNITS    = 2,
    parameter int ZERO_UNITS   = 1,
    parameter int GAP_UNITS    = 1,
    parameter int CARRIER_HALF = 312
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        send,
    input  logic [11:0] command,
    output logic        ir_out,
    output logic        busy,
    output logic        done,
    output logic [3:0]  state
);

    localparam logic [3:0] IDLE  = 4'd0;
    localparam logic [3:0] START = 4'd1;
    localparam logic [3:0] GAP   = 4'd2;
    localparam logic [3:0] MARK  = 4'd3;
    localparam logic [3:0] END   = 4'd4;

    localparam logic [19:0] START_LAST = 20'(START_UNITS * UNIT - 1);
    localparam logic [19:0] ONE_LAST   = 20'(ONE_UNITS * UNIT - 1);
    localparam logic [19:0] ZERO_LAST  = 20'(ZERO_UNITS * UNIT - 1);
    localparam logic [19:0] GAP_LAST   = 20'(GAP_UNITS * UNIT - 1);
    localparam logic [9:0]  CAR_LAST   = 10'(CARRIER_HALF - 1);

    logic [3:0]  state_q, state_d;
    logic [19:0] dur_q, dur_d;
    logic [9:0]  car_q, car_d;
    logic        phase_q, phase_d;
    logic [3:0]  bit_q, bit_d;
    logic [11:0] cmd_q, cmd_d;
    logic        ir_out_q, ir_out_d;
    logic        done_q, done_d;
    logic [19:0] mark_last;

    assign mark_last = cmd_q[bit_q] ? ONE_LAST : ZERO_LAST;

    always_comb begin
        state_d = state_q;
        dur_d   = dur_q;
        car_d   = car_q;
        phase_d = phase_q;
        bit_d   = bit_q;
        cmd_d   = cmd_q;
        done_d  = 1'b0;

        // Carrier free-runs while a mark is on; entry points below override it.
        if (car_q == CAR_LAST) begin
            car_d   = 10'd0;
            phase_d = ~phase_q;
        end else begin
            car_d = car_q + 10'd1;
        end

        case (state_q)
            IDLE: begin
                car_d   = car_q;
                phase_d = phase_q;
                if (send) begin
                    cmd_d   = command;
                    bit_d   = 4'd0;
                    dur_d   = 20'd0;
                    car_d   = 10'd0;
                    phase_d = 1'b1;
                    state_d = START;
                end
            end
            START: begin
                if (dur_q == START_LAST) begin
                    dur_d   = 20'd0;
                    state_d = GAP;
                end else begin
                    dur_d = dur_q + 20'd1;
                end
            end
            GAP: begin
                if (dur_q == GAP_LAST) begin
                    dur_d   = 20'd0;
                    car_d   = 10'd0;
                    phase_d = 1'b1;
                    state_d = MARK;
                end else begin
                    dur_d = dur_q + 20'd1;
                end
            end
            MARK: begin
                if (dur_q == mark_last) begin
                    dur_d = 20'd0;
                    if (bit_q == 4'd11) begin
                        state_d = END;
                    end else begin
                        bit_d   = bit_q + 4'd1;
                        state_d = GAP;
                    end
                end else begin
                    dur_d = dur_q + 20'd1;
                end
            end
            END: begin
                if (dur_q == GAP_LAST) begin
                    dur_d   = 20'd0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    dur_d = dur_q + 20'd1;
                end
            end
            default: begin
                dur_d   = 20'd0;
                state_d = IDLE;
            end
        endcase

        // Registered so the LED drive changes on the same edge as the state.
        ir_out_d = phase_d && ((state_d == START) || (state_d == MARK));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            dur_q    <= 20'd0;
            car_q    <= 10'd0;
            phase_q  <= 1'b0;
            bit_q    <= 4'd0;
            cmd_q    <= 12'd0;
            ir_out_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            dur_q    <= dur_d;
            car_q    <= car_d;
            phase_q  <= phase_d;
            bit_q    <= bit_d;
            cmd_q    <= cmd_d;
            ir_out_q <= ir_out_d;
            done_q   <= done_d;
        end
    end

    assign ir_out = ir_out_q;
    assign done   = done_q;
    assign state  = state_q;
    assign busy   = (state_q != IDLE);

endmodule

// File: tb/tb_ir_transmitter.sv
// Scoreboard bench for ir_transmitter: expected per-cycle outputs and busy
// lengths are queued when a send is issued and compared as the DUT runs.
module tb_ir_transmitter;

    localparam int UNIT = 10;
    localparam int CH   = 2;

    logic        clock = 1'b0;
    logic        reset;
    logic        send;
    logic [11:0] command;
    logic        ir_out;
    logic        busy;
    logic        done;
    logic [3:0]  state;

    ir_transmitter #(
        .UNIT(UNIT), .START_UNITS(4), .ONE_UNITS(2), .ZERO_UNITS(1),
        .GAP_UNITS(1), .CARRIER_HALF(CH)
    ) dut (
        .clock(clock), .reset(reset), .send(send), .command(command),
        .ir_out(ir_out), .busy(busy), .done(done), .state(state)
    );

    always #5 clock = ~clock;

    // Entry layout: {state[3:0], busy, done, ir_out}
    logic [6:0] exp_q[$];
    int         len_q[$];
    int         checks = 0;
    int         errors = 0;
    bit         mon_en = 1'b0;
    int         busy_run = 0;
    logic [6:0] obs, expv;
    int         exp_len;

    task automatic push_seg(input logic [3:0] st, input int len, input bit carrier);
        for (int k = 0; k < len; k++) begin
            logic ir;
            ir = carrier && (((k / CH) % 2) == 0);
            exp_q.push_back({st, 1'b1, 1'b0, ir});
        end
    endtask

    task automatic push_frame(input logic [11:0] cmd);
        push_seg(4'd1, 4 * UNIT, 1'b1);
        for (int i = 0; i < 12; i++) begin
            push_seg(4'd2, UNIT, 1'b0);
            push_seg(4'd3, cmd[i] ? 2 * UNIT : UNIT, 1'b1);
        end
        push_seg(4'd4, UNIT, 1'b0);
        exp_q.push_back(7'b0000_010);
        len_q.push_back(UNIT * (29 + $countones(cmd)));
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (exp_q.size() > 0 && t < 3000) begin
            @(negedge clock);
            t++;
        end
        checks++;
        assert (exp_q.size() == 0) else begin
            errors++;
            $error("FAIL drain_timeout: remaining=%0d required=0", exp_q.size());
        end
        repeat (3) @(negedge clock);
    endtask

    // Monitor samples two time units after each active edge.
    always @(posedge clock) begin
        #2;
        if (mon_en) begin
            obs  = {state, busy, done, ir_out};
            expv = (exp_q.size() > 0) ? exp_q.pop_front() : 7'b0;
            checks++;
            assert (obs === expv) else begin
                errors++;
                $error("FAIL cycle_outputs: observed {st,busy,done,ir}=%b required=%b", obs, expv);
            end
            if (busy === 1'b1) begin
                busy_run++;
            end else if (busy_run > 0) begin
                exp_len = (len_q.size() > 0) ? len_q.pop_front() : -1;
                checks++;
                assert (busy_run == exp_len) else begin
                    errors++;
                    $error("FAIL busy_length: observed=%0d required=%0d", busy_run, exp_len);
                end
                busy_run = 0;
            end
        end
    end

    initial begin
        reset   = 1'b1;
        send    = 1'b0;
        command = 12'h000;
        repeat (3) @(negedge clock);
        checks++;
        assert (ir_out === 1'b0) else begin errors++; $error("FAIL reset_ir_out: observed=%b required=0", ir_out); end
        checks++;
        assert (busy === 1'b0) else begin errors++; $error("FAIL reset_busy: observed=%b required=0", busy); end
        checks++;
        assert (done === 1'b0) else begin errors++; $error("FAIL reset_done: observed=%b required=0", done); end
        checks++;
        assert (state === 4'd0) else begin errors++; $error("FAIL reset_state: observed=%0d required=0", state); end
        reset  = 1'b0;
        mon_en = 1'b1;
        @(negedge clock);

        // All-zero command
        command = 12'h000; send = 1'b1; push_frame(12'h000);
        @(negedge clock); send = 1'b0;
        wait_drain();

        // Bit order: first and last marks long
        command = 12'h801; send = 1'b1; push_frame(12'h801);
        @(negedge clock); send = 1'b0;
        wait_drain();

        // All ones, command changed mid-frame
        command = 12'hFFF; send = 1'b1; push_frame(12'hFFF);
        @(negedge clock); send = 1'b0;
        repeat (49) @(negedge clock);
        command = 12'h000;
        wait_drain();

        // Send pulse while busy is ignored
        command = 12'h0A5; send = 1'b1; push_frame(12'h0A5);
        @(negedge clock); send = 1'b0;
        repeat (99) @(negedge clock);
        command = 12'hFFF; send = 1'b1;
        @(negedge clock); send = 1'b0;
        wait_drain();

        // send held high: back-to-back frames
        command = 12'h3C0; send = 1'b1; push_frame(12'h3C0); push_frame(12'h3C0);
        repeat (335) @(negedge clock);
        send = 1'b0;
        wait_drain();

        // Reset during the fifth data mark
        command = 12'h000; send = 1'b1; push_frame(12'h000);
        @(negedge clock); send = 1'b0;
        repeat (134) @(negedge clock);
        exp_q.delete();
        len_q.delete();
        len_q.push_back(135);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        checks++;
        assert (state === 4'd0 && busy === 1'b0 && ir_out === 1'b0 && done === 1'b0) else begin
            errors++;
            $error("FAIL abort_reset: observed st=%0d busy=%b ir=%b done=%b required 0/0/0/0", state, busy, ir_out, done);
        end
        repeat (3) @(negedge clock);

        // Fresh frame after abort
        command = 12'h555; send = 1'b1; push_frame(12'h555);
        @(negedge clock); send = 1'b0;
        wait_drain();

        checks++;
        assert (len_q.size() == 0) else begin
            errors++;
            $error("FAIL frames_pending: observed=%0d required=0", len_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
